// File: rtl/adder_pkg.sv
// Shared constants, sizing helper and stage-record layout for the pipelined adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 4;

  // Bits handled by each pipeline stage.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Stage-register record at the default size. The top level declares the
  // same record sized to its own WIDTH parameter.
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] sum_lo;
    logic [DEFAULT_WIDTH-1:0] a_hi;
    logic [DEFAULT_WIDTH-1:0] b_hi;
  } stage_rec_t;

endpackage

// File: rtl/adder_bit.sv
// One-bit full adder cell.
module adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from adder_bit cells. Also exposes
// the carry into its top bit so the final stage can derive signed overflow.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int CHUNK = chunk_w(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout,
  output logic             o_c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    adder_bit u_bit (
      .i_a    (i_a[i]),
      .i_b    (i_b[i]),
      .i_cin  (w_c[i]),
      .o_s    (o_s[i]),
      .o_cout (w_c[i+1])
    );
  end

  assign o_cout     = w_c[CHUNK];
  assign o_c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per stage, carry registered
// between stages, globally stalled when the output is held.
//
// Handshake: a beat moves on the input side when i_in_valid && o_in_ready and
// on the output side when o_out_valid && i_out_ready. The whole pipe advances
// together whenever the output register is empty or being drained, so
// o_in_ready is that advance condition and bubbles are never squeezed out.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  // Same layout as adder_pkg::stage_rec_t, sized to this instance.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
  } stage_t;

  logic w_advance;
  logic w_overflow;
  logic r_overflow;

  assign w_advance  = !g_stage[STAGES-1].r_q.valid || i_out_ready;
  assign o_in_ready = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_src;
    stage_t           w_nxt;
    stage_t           r_q;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;
    logic             w_c_msb_in;
    logic             w_unused_sum;

    if (k == 0) begin : g_head
      assign w_src = '{valid: i_in_valid, carry: i_carry_in, sum_lo: '0,
                       a_hi: i_a, b_hi: i_b};
    end else begin : g_body
      assign w_src = g_stage[k-1].r_q;
    end

    // This stage's chunk position of the incoming sum is overwritten below.
    assign w_unused_sum = ^w_src.sum_lo[k*CHUNK +: CHUNK];

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a        (w_src.a_hi[k*CHUNK +: CHUNK]),
      .i_b        (w_src.b_hi[k*CHUNK +: CHUNK]),
      .i_cin      (w_src.carry),
      .o_s        (w_s),
      .o_cout     (w_cout),
      .o_c_msb_in (w_c_msb_in)
    );

    // Insert this stage's chunk sum and carry into the passing record.
    always_comb begin
      w_nxt                            = w_src;
      w_nxt.sum_lo[k*CHUNK +: CHUNK]   = w_s;
      w_nxt.carry                      = w_cout;
    end

    // Stage register: cleared by reset, frozen on a global stall.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_q <= '0;
      end else if (w_advance) begin
        r_q <= w_nxt;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic w_unused_ops;
      // Operand bits are fully consumed once the last chunk is added.
      assign w_unused_ops = ^{r_q.a_hi, r_q.b_hi};
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  assign w_overflow = g_stage[STAGES-1].w_c_msb_in ^ g_stage[STAGES-1].w_cout;

  // Overflow flag travels alongside the last stage register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (w_advance) begin
      r_overflow <= w_overflow;
    end
  end

  assign o_out_valid = g_stage[STAGES-1].r_q.valid;
  assign o_sum       = g_stage[STAGES-1].r_q.sum_lo;
  assign o_carry_out = g_stage[STAGES-1].r_q.carry;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (STAGES = 4, 1, 8, WIDTH = 8),
// each with its own driver, expected queue and output monitor.
module tb_pipelined_adder;

  localparam int W      = 8;
  localparam int N_CFG  = 3;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done   = 0;

  task automatic check(input string name, input int stages,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (STAGES=%0d): got %0h expected %0h at t=%0t",
               name, stages, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic, returns {overflow, carry, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta,
                                         input logic [W-1:0] tb,
                                         input logic tc);
    int u, sa, sb, sv;
    logic ovf;
    logic [W:0] uw;
    u  = int'(ta) + int'(tb) + int'(tc);
    sa = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
    sb = tb[W-1] ? int'(tb) - (1 << W) : int'(tb);
    sv = sa + sb + int'(tc);
    ovf = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
    uw  = u[W:0];
    return {ovf, uw};
  endfunction

  for (genvar g = 0; g < N_CFG; g++) begin : g_cfg
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic         cin, cout, ovf;
    logic [W-1:0] a, b, sum;

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    int           lat_q[$];
    bit           lat_en;
    bit           rnd_done;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_a         (a),
      .i_b         (b),
      .i_carry_in  (cin),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_sum       (sum),
      .o_carry_out (cout),
      .o_overflow  (ovf)
    );

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns on a falling edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc);
      int waited = 0;
      in_valid = 1'b1; a = ta; b = tb; cin = tc;
      #1;
      while (!in_ready && waited < 50) begin
        @(negedge clk); #1; waited++;
      end
      if (!in_ready) begin
        check("send_timeout", S, 0, 1);
      end else begin
        exp_q.push_back(model(ta, tb, tc));
        lat_q.push_back(lat_en ? cyc : -1);
      end
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk); n++;
      end
      check("drain", S, exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
      logic [W+1:0] e;
      #2;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", S, 1, 0);
        end else begin
          e = exp_q[0];
          check(out_ready ? "sum" : "sum_hold", S, sum, e[W-1:0]);
          check(out_ready ? "carry" : "carry_hold", S, cout, e[W]);
          check(out_ready ? "overflow" : "overflow_hold", S, ovf, e[W+1]);
          if (out_ready) begin
            if (lat_q[0] >= 0) check("latency", S, cyc - lat_q[0], S);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
    end

    // ---------------- stimulus ----------------
    initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; lat_en = 1'b1; rnd_done = 1'b0;

      // Reset held two cycles.
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", S, out_valid, 0);
      check("rst_sum", S, sum, 0);
      check("rst_carry", S, cout, 0);
      check("rst_overflow", S, ovf, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", S, in_ready, 1);
      @(negedge clk);

      // Directed carry-ripple and overflow corners.
      send(8'hFF, 8'h01, 1'b0);
      send(8'h7F, 8'h01, 1'b0);
      send(8'h80, 8'hFF, 1'b1);
      drain();

      // Twenty random back-to-back pairs with the output always ready.
      for (int i = 0; i < 20; i++)
        send(W'($urandom), W'($urandom), 1'($urandom));
      drain();

      // Full pipe, then output held off for three cycles.
      lat_en = 1'b0;
      fork
        begin
          for (int i = 0; i < 2 * S + 4; i++)
            send(W'($urandom), W'($urandom), 1'($urandom));
        end
        begin
          repeat (S) @(negedge clk);
          for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            #3;
            check("in_ready_stall", S, in_ready, 0);
            @(negedge clk);
          end
          out_ready = 1'b1;
        end
      join
      drain();

      // Random bubbles and random backpressure.
      fork
        begin
          for (int i = 0; i < 30; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 1)) @(negedge clk);
          end
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
          end
          out_ready = 1'b1;
        end
      join
      drain();

      // Reset with results in flight: none of them may emerge afterwards.
      for (int i = 0; i < 3; i++)
        send(W'($urandom), W'($urandom), 1'($urandom));
      rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      #1;
      check("flush_out_valid", S, out_valid, 0);
      check("flush_sum", S, sum, 0);
      check("flush_carry", S, cout, 0);
      check("flush_overflow", S, ovf, 0);
      rst = 1'b0;
      #1;
      check("flush_in_ready", S, in_ready, 1);
      repeat (S + 4) @(negedge clk);

      // Recovery after the flush.
      lat_en = 1'b1;
      send(8'hFF, 8'h01, 1'b0);
      send(8'h7F, 8'h01, 1'b0);
      drain();

      done++;
    end
  end

  // ---------------- final report ----------------
  initial begin
    int n = 0;
    while (done != N_CFG && n < 20000) begin
      @(negedge clk); n++;
    end
    check("all_done", 0, done, N_CFG);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
